// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: source select, load size and FSM state.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_CSR  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the addressed lane out of a naturally
// aligned data word, sign- or zero-extends it to XLEN, and flags
// misaligned or illegal-size accesses for the same size/offset pair.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int AW  = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [AW-1:0]   addr_lo,
    output logic [XLEN-1:0] result,
    output logic            misaligned,
    output logic            illegal
);

    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] mask_s;
    logic            sign_s;

    // Shift the addressed lane down to bit 0, then mask and extend by size.
    always_comb begin
        shifted_s  = data >> {addr_lo, 3'b000};
        mask_s     = '0;
        sign_s     = 1'b0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (ld_size_e'(size))
            LD_B: begin
                mask_s[7:0] = 8'hFF;
                sign_s      = shifted_s[7];
            end
            LD_H: begin
                mask_s[15:0] = 16'hFFFF;
                sign_s       = shifted_s[15];
                misaligned   = addr_lo[0];
            end
            LD_W: begin
                // On XLEN=64 the upper half of the mask stays clear so the
                // word is extended to the full 64 bits.
                mask_s[31:0] = 32'hFFFF_FFFF;
                sign_s       = shifted_s[31];
                misaligned   = (addr_lo[1:0] != 2'b00);
            end
            LD_D: begin
                mask_s     = '1;
                sign_s     = 1'b0;
                misaligned = (addr_lo != '0);
                illegal    = (XLEN == 32);
            end
            default: begin
                mask_s = '1;
                sign_s = 1'b0;
            end
        endcase
        result = (shifted_s & mask_s) | (~mask_s & {XLEN{sign_s & ~uns}});
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU/load/PC+4/CSR data, waits for the load
// response with a timeout, and issues one registered register-file write
// per retired instruction. Also exposes the outstanding load destination.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int TIMEOUT   = 255,
    localparam int AW       = $clog2(XLEN / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rd_we,
    input  logic [1:0]           in_wb_sel,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_pc_plus4,
    input  logic [XLEN-1:0]      in_csr_rdata,
    input  logic [1:0]           in_ld_size,
    input  logic                 in_ld_unsigned,
    input  logic [AW-1:0]        in_addr_lo,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_rerr,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 pend_valid,
    output logic [REG_IDX_W-1:0] pend_rd,
    output logic                 load_fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_e            state_q,      state_d;
    logic                 rf_we_q,      rf_we_d;
    logic [REG_IDX_W-1:0] rf_waddr_q,   rf_waddr_d;
    logic [XLEN-1:0]      rf_wdata_q,   rf_wdata_d;
    logic                 load_fault_q, load_fault_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [REG_IDX_W-1:0] pend_rd_q,    pend_rd_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [REG_IDX_W-1:0] ld_rd_q,      ld_rd_d;
    logic                 ld_rd_we_q,   ld_rd_we_d;
    logic [1:0]           ld_size_q,    ld_size_d;
    logic                 ld_uns_q,     ld_uns_d;
    logic [AW-1:0]        ld_addr_q,    ld_addr_d;

    logic [1:0]           al_size_s;
    logic                 al_uns_s;
    logic [AW-1:0]        al_addr_s;
    logic [XLEN-1:0]      al_result_s;
    logic                 al_misaligned_s;
    logic                 al_illegal_s;
    logic [XLEN-1:0]      sel_data_s;

    // The aligner checks the incoming request while idle and extracts the
    // captured lane while a load is outstanding.
    always_comb begin
        if (state_q == ST_WAIT_LOAD) begin
            al_size_s = ld_size_q;
            al_uns_s  = ld_uns_q;
            al_addr_s = ld_addr_q;
        end else begin
            al_size_s = in_ld_size;
            al_uns_s  = in_ld_unsigned;
            al_addr_s = in_addr_lo;
        end
    end

    load_align #(
        .XLEN (XLEN)
    ) u_align (
        .data       (mem_rdata),
        .size       (al_size_s),
        .uns        (al_uns_s),
        .addr_lo    (al_addr_s),
        .result     (al_result_s),
        .misaligned (al_misaligned_s),
        .illegal    (al_illegal_s)
    );

    // Non-load write data source select.
    always_comb begin
        case (wb_sel_e'(in_wb_sel))
            WB_ALU:  sel_data_s = in_alu_result;
            WB_PC4:  sel_data_s = in_pc_plus4;
            WB_CSR:  sel_data_s = in_csr_rdata;
            default: sel_data_s = in_alu_result;
        endcase
    end

    // Next-state and next-output computation for the write-back FSM.
    always_comb begin
        state_d      = state_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        load_fault_d = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_rd_d    = pend_rd_q;
        cnt_d        = cnt_q;
        ld_rd_d      = ld_rd_q;
        ld_rd_we_d   = ld_rd_we_q;
        ld_size_d    = ld_size_q;
        ld_uns_d     = ld_uns_q;
        ld_addr_d    = ld_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (wb_sel_e'(in_wb_sel) == WB_LOAD) begin
                        if (al_misaligned_s | al_illegal_s) begin
                            load_fault_d = 1'b1;
                        end else begin
                            ld_rd_d      = in_rd;
                            ld_rd_we_d   = in_rd_we;
                            ld_size_d    = in_ld_size;
                            ld_uns_d     = in_ld_unsigned;
                            ld_addr_d    = in_addr_lo;
                            cnt_d        = '0;
                            pend_valid_d = 1'b1;
                            pend_rd_d    = in_rd_we ? in_rd : '0;
                            state_d      = ST_WAIT_LOAD;
                        end
                    end else begin
                        rf_we_d    = in_rd_we & (in_rd != '0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = sel_data_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // A response in the final timeout cycle still wins.
                if (mem_rvalid) begin
                    state_d      = ST_IDLE;
                    pend_valid_d = 1'b0;
                    pend_rd_d    = '0;
                    if (mem_rerr) begin
                        load_fault_d = 1'b1;
                    end else begin
                        rf_we_d    = ld_rd_we_q & (ld_rd_q != '0);
                        rf_waddr_d = ld_rd_q;
                        rf_wdata_d = al_result_s;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_IDLE;
                    pend_valid_d = 1'b0;
                    pend_rd_d    = '0;
                    load_fault_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_LOAD;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                pend_valid_d = 1'b0;
                pend_rd_d    = '0;
            end
        endcase
    end

    // State and output registers; reset drops any outstanding load silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            load_fault_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            cnt_q        <= '0;
            ld_rd_q      <= '0;
            ld_rd_we_q   <= 1'b0;
            ld_size_q    <= 2'b00;
            ld_uns_q     <= 1'b0;
            ld_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            load_fault_q <= load_fault_d;
            pend_valid_q <= pend_valid_d;
            pend_rd_q    <= pend_rd_d;
            cnt_q        <= cnt_d;
            ld_rd_q      <= ld_rd_d;
            ld_rd_we_q   <= ld_rd_we_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
            ld_addr_q    <= ld_addr_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign load_fault = load_fault_q;
    assign pend_valid = pend_valid_q;
    assign pend_rd    = pend_rd_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a 32-bit instance with TIMEOUT=4 and a
// 64-bit instance for the wide-word extension cases.
module tb_wb_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit instance signals
    logic        in_valid = 1'b0, in_rd_we = 1'b0, in_ld_unsigned = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic [1:0]  in_wb_sel = 2'd0, in_ld_size = 2'd0, in_addr_lo = 2'd0;
    logic [31:0] in_alu_result = 32'd0, in_pc_plus4 = 32'd0, in_csr_rdata = 32'd0;
    logic        mem_rvalid = 1'b0, mem_rerr = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        in_ready, rf_we, pend_valid, load_fault;
    logic [4:0]  rf_waddr, pend_rd;
    logic [31:0] rf_wdata;

    // 64-bit instance signals
    logic        v_valid = 1'b0, v_rd_we = 1'b0, v_uns = 1'b0;
    logic [4:0]  v_rd = 5'd0;
    logic [1:0]  v_sel = 2'd0, v_size = 2'd0;
    logic [2:0]  v_addr = 3'd0;
    logic [63:0] v_zero = 64'd0;
    logic        v_rvalid = 1'b0;
    logic [63:0] v_rdata = 64'd0;
    logic        v_ready, v_we, v_pend_valid, v_fault;
    logic [4:0]  v_waddr, v_pend_rd;
    logic [63:0] v_wdata;

    wb_stage #(.XLEN(32), .REG_IDX_W(5), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .in_csr_rdata(in_csr_rdata), .in_ld_size(in_ld_size),
        .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_valid(pend_valid), .pend_rd(pend_rd), .load_fault(load_fault)
    );

    wb_stage #(.XLEN(64), .REG_IDX_W(5), .TIMEOUT(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v_valid), .in_ready(v_ready),
        .in_rd(v_rd), .in_rd_we(v_rd_we), .in_wb_sel(v_sel),
        .in_alu_result(v_zero), .in_pc_plus4(v_zero),
        .in_csr_rdata(v_zero), .in_ld_size(v_size),
        .in_ld_unsigned(v_uns), .in_addr_lo(v_addr),
        .mem_rvalid(v_rvalid), .mem_rdata(v_rdata), .mem_rerr(1'b0),
        .rf_we(v_we), .rf_waddr(v_waddr), .rf_wdata(v_wdata),
        .pend_valid(v_pend_valid), .pend_rd(v_pend_rd), .load_fault(v_fault)
    );

    // Count one comparison and report it when the observed value differs.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one load on the 32-bit instance. resp_cyc < 0: rejected at accept;
    // 0: no response (timeout); n: response in the n-th wait cycle.
    task automatic run_load(input string tag, input logic [4:0] rd, input logic rd_we,
                            input logic [1:0] size, input logic uns, input logic [1:0] addr,
                            input int resp_cyc, input logic rerr, input logic [31:0] data,
                            input logic exp_we, input logic [31:0] exp_data, input logic exp_fault);
        logic [4:0] exp_prd;
        exp_prd = rd_we ? rd : 5'd0;
        in_valid = 1'b1; in_wb_sel = 2'd1; in_rd = rd; in_rd_we = rd_we;
        in_ld_size = size; in_ld_unsigned = uns; in_addr_lo = addr;
        step();
        in_valid = 1'b0;
        if (resp_cyc < 0) begin
            check_eq($sformatf("%s_fault", tag), 64'(load_fault), 64'(exp_fault));
            check_eq($sformatf("%s_we", tag), 64'(rf_we), 64'd0);
            check_eq($sformatf("%s_pend", tag), 64'(pend_valid), 64'd0);
            check_eq($sformatf("%s_ready", tag), 64'(in_ready), 64'd1);
        end else begin
            for (int i = 1; i <= 4; i++) begin
                check_eq($sformatf("%s_pend%0d", tag, i), 64'(pend_valid), 64'd1);
                check_eq($sformatf("%s_prd%0d", tag, i), 64'(pend_rd), 64'(exp_prd));
                check_eq($sformatf("%s_busy%0d", tag, i), 64'(in_ready), 64'd0);
                if (i == resp_cyc) begin
                    mem_rvalid = 1'b1; mem_rerr = rerr; mem_rdata = data;
                end
                step();
                if (i == resp_cyc) break;
            end
            mem_rvalid = 1'b0; mem_rerr = 1'b0;
            check_eq($sformatf("%s_we", tag), 64'(rf_we), 64'(exp_we));
            check_eq($sformatf("%s_fault", tag), 64'(load_fault), 64'(exp_fault));
            check_eq($sformatf("%s_pend_end", tag), 64'(pend_valid), 64'd0);
            check_eq($sformatf("%s_ready", tag), 64'(in_ready), 64'd1);
            if (exp_we) begin
                check_eq($sformatf("%s_addr", tag), 64'(rf_waddr), 64'(rd));
                check_eq($sformatf("%s_data", tag), 64'(rf_wdata), 64'(exp_data));
            end
        end
        step();
        check_eq($sformatf("%s_we_pulse", tag), 64'(rf_we), 64'd0);
        check_eq($sformatf("%s_fault_pulse", tag), 64'(load_fault), 64'd0);
    endtask

    // One load on the 64-bit instance with an immediate response.
    task automatic run64(input string tag, input logic [1:0] size, input logic uns,
                         input logic [2:0] addr, input logic [63:0] data, input logic [63:0] exp);
        v_valid = 1'b1; v_sel = 2'd1; v_rd = 5'd3; v_rd_we = 1'b1;
        v_size = size; v_uns = uns; v_addr = addr;
        step();
        v_valid = 1'b0;
        check_eq($sformatf("%s_pend", tag), 64'(v_pend_valid), 64'd1);
        v_rvalid = 1'b1; v_rdata = data;
        step();
        v_rvalid = 1'b0;
        check_eq($sformatf("%s_we", tag), 64'(v_we), 64'd1);
        check_eq($sformatf("%s_data", tag), v_wdata, exp);
        check_eq($sformatf("%s_fault", tag), 64'(v_fault), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check_eq("rst_we", 64'(rf_we), 64'd0);
        check_eq("rst_waddr", 64'(rf_waddr), 64'd0);
        check_eq("rst_wdata", 64'(rf_wdata), 64'd0);
        check_eq("rst_fault", 64'(load_fault), 64'd0);
        check_eq("rst_pend", 64'(pend_valid), 64'd0);
        check_eq("rst_prd", 64'(pend_rd), 64'd0);
        check_eq("rst_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        step();

        // ALU writes back to back
        in_valid = 1'b1; in_wb_sel = 2'd0; in_rd_we = 1'b1;
        in_rd = 5'd5; in_alu_result = 32'h0000_1234;
        in_pc_plus4 = 32'h0000_0104; in_csr_rdata = 32'h0000_0C5A;
        step();
        check_eq("alu1_we", 64'(rf_we), 64'd1);
        check_eq("alu1_addr", 64'(rf_waddr), 64'd5);
        check_eq("alu1_data", 64'(rf_wdata), 64'h1234);
        check_eq("alu1_ready", 64'(in_ready), 64'd1);
        in_rd = 5'd6; in_alu_result = 32'h0000_BEEF;
        step();
        check_eq("alu2_we", 64'(rf_we), 64'd1);
        check_eq("alu2_addr", 64'(rf_waddr), 64'd6);
        check_eq("alu2_data", 64'(rf_wdata), 64'hBEEF);
        check_eq("alu2_ready", 64'(in_ready), 64'd1);
        // PC+4 and CSR sources
        in_rd = 5'd1; in_wb_sel = 2'd2;
        step();
        check_eq("pc4_data", 64'(rf_wdata), 64'h0104);
        in_rd = 5'd2; in_wb_sel = 2'd3;
        step();
        check_eq("csr_data", 64'(rf_wdata), 64'h0C5A);
        // x0 and rd_we=0 never write
        in_rd = 5'd0; in_wb_sel = 2'd0;
        step();
        check_eq("alu_x0_we", 64'(rf_we), 64'd0);
        in_rd = 5'd9; in_rd_we = 1'b0;
        step();
        check_eq("alu_nowe_we", 64'(rf_we), 64'd0);
        in_valid = 1'b0;
        step();
        check_eq("idle_we", 64'(rf_we), 64'd0);

        // Loads: sign/zero extension, alignment checks, timeout, errors
        run_load("lb",     5'd7,  1'b1, 2'd0, 1'b0, 2'd3, 4, 1'b0, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80, 1'b0);
        run_load("lbu",    5'd7,  1'b1, 2'd0, 1'b1, 2'd3, 2, 1'b0, 32'h80FF_0000, 1'b1, 32'h0000_0080, 1'b0);
        run_load("lb1",    5'd9,  1'b1, 2'd0, 1'b0, 2'd1, 3, 1'b0, 32'h80FF_7F00, 1'b1, 32'h0000_007F, 1'b0);
        run_load("lh",     5'd8,  1'b1, 2'd1, 1'b0, 2'd2, 1, 1'b0, 32'h80FF_0000, 1'b1, 32'hFFFF_80FF, 1'b0);
        run_load("lhu",    5'd8,  1'b1, 2'd1, 1'b1, 2'd2, 1, 1'b0, 32'h80FF_0000, 1'b1, 32'h0000_80FF, 1'b0);
        run_load("lw_mis", 5'd10, 1'b1, 2'd2, 1'b0, 2'd2, -1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        run_load("lh_mis", 5'd10, 1'b1, 2'd1, 1'b0, 2'd1, -1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        run_load("ld_ill", 5'd10, 1'b1, 2'd3, 1'b0, 2'd0, -1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        run_load("tmo",    5'd11, 1'b1, 2'd2, 1'b0, 2'd0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        run_load("edge4",  5'd11, 1'b1, 2'd2, 1'b0, 2'd0, 4, 1'b0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0);
        run_load("berr",   5'd12, 1'b1, 2'd2, 1'b0, 2'd0, 2, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
        run_load("ld_x0",  5'd0,  1'b1, 2'd2, 1'b0, 2'd0, 1, 1'b0, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0);
        run_load("ld_nowe",5'd13, 1'b0, 2'd2, 1'b0, 2'd0, 1, 1'b0, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0);

        // Reset while waiting for a load
        in_valid = 1'b1; in_wb_sel = 2'd1; in_rd = 5'd4; in_rd_we = 1'b1;
        in_ld_size = 2'd2; in_ld_unsigned = 1'b0; in_addr_lo = 2'd0;
        step();
        in_valid = 1'b0;
        step();
        check_eq("mid_pend", 64'(pend_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("mrst_we", 64'(rf_we), 64'd0);
        check_eq("mrst_waddr", 64'(rf_waddr), 64'd0);
        check_eq("mrst_wdata", 64'(rf_wdata), 64'd0);
        check_eq("mrst_fault", 64'(load_fault), 64'd0);
        check_eq("mrst_pend", 64'(pend_valid), 64'd0);
        check_eq("mrst_prd", 64'(pend_rd), 64'd0);
        check_eq("mrst_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        check_eq("stray_we", 64'(rf_we), 64'd0);
        check_eq("stray_fault", 64'(load_fault), 64'd0);
        check_eq("stray_wdata", 64'(rf_wdata), 64'd0);
        check_eq("stray_ready", 64'(in_ready), 64'd1);

        // 64-bit datapath
        run64("lw64",  2'd2, 1'b0, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
        run64("lwu64", 2'd2, 1'b1, 3'd4, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);
        run64("ld64",  2'd3, 1'b0, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        run64("lb64",  2'd0, 1'b0, 3'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
